// File: rtl/decode_arith_stage.sv
// ============================================================================
// Module   : decode_arith_stage
// Brief    : Registered RV32I/RV64I OP/OP-IMM decode behind a 2-entry skid
//            buffer, with a saturating illegal-word counter.
//            Define DECODE_ARITH_MEXT_EN to decode the M-extension ops.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module decode_arith_stage #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [4:0]       out_kind,
    output logic             out_is_imm,
    output logic             out_is_arith,
    output logic             out_illegal,
    output logic [4:0]       out_rd,
    output logic [4:0]       out_rs1,
    output logic [4:0]       out_rs2,
    output logic [XLEN-1:0]  out_imm,
    output logic [CNT_W-1:0] illegal_count
);

    localparam int       c_SHAMT_W   = (XLEN == 64) ? 6 : 5;
    localparam logic [6:0] c_OPC_OPIMM = 7'b0010011;
    localparam logic [6:0] c_OPC_OP    = 7'b0110011;

    localparam logic [4:0] c_K_ADD = 5'd0,  c_K_SUB = 5'd1,  c_K_SLL = 5'd2;
    localparam logic [4:0] c_K_SLT = 5'd3,  c_K_SLTU = 5'd4, c_K_XOR = 5'd5;
    localparam logic [4:0] c_K_SRL = 5'd6,  c_K_SRA = 5'd7,  c_K_OR  = 5'd8;
    localparam logic [4:0] c_K_AND = 5'd9,  c_K_INVALID = 5'd31;

    typedef struct packed {
        logic [4:0]      kind;
        logic            is_imm;
        logic            is_arith;
        logic            illegal;
        logic [4:0]      rd;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [XLEN-1:0] imm;
    } bundle_t;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    state_t            r_state, w_next_state;
    bundle_t           r_main, r_skid, w_dec;
    logic [CNT_W-1:0]  r_illegal_count;
    logic              w_accept, w_out_hs;
    logic              w_load_main_in, w_load_main_skid, w_load_skid;
    logic              w_hi_zero, w_hi_sra;
    logic [2:0]        w_funct3;
    logic [6:0]        w_funct7;
    logic [XLEN-1:0]   w_imm_i, w_shamt;

    assign w_funct3 = in_instr[14:12];
    assign w_funct7 = in_instr[31:25];
    assign w_imm_i  = {{(XLEN-12){in_instr[31]}}, in_instr[31:20]};
    assign w_shamt  = {{(XLEN-c_SHAMT_W){1'b0}}, in_instr[20 +: c_SHAMT_W]};

    // On RV32 bit 25 belongs to the checked field, so a set bit 25 is illegal
    generate
        if (XLEN == 64) begin : g_shift_chk64
            assign w_hi_zero = (in_instr[31:26] == 6'b000000);
            assign w_hi_sra  = (in_instr[31:26] == 6'b010000);
        end else begin : g_shift_chk32
            assign w_hi_zero = (in_instr[31:25] == 7'b0000000);
            assign w_hi_sra  = (in_instr[31:25] == 7'b0100000);
        end
    endgenerate

    function automatic logic [4:0] base_kind(input logic [2:0] f3);
        case (f3)
            3'b000:  base_kind = c_K_ADD;
            3'b001:  base_kind = c_K_SLL;
            3'b010:  base_kind = c_K_SLT;
            3'b011:  base_kind = c_K_SLTU;
            3'b100:  base_kind = c_K_XOR;
            3'b101:  base_kind = c_K_SRL;
            3'b110:  base_kind = c_K_OR;
            default: base_kind = c_K_AND;
        endcase
    endfunction

    // Non-arithmetic words keep kind=INVALID, imm=0 and raw register fields
    always_comb begin
        w_dec      = '0;
        w_dec.kind = c_K_INVALID;
        w_dec.rd   = in_instr[11:7];
        w_dec.rs1  = in_instr[19:15];
        w_dec.rs2  = in_instr[24:20];
        if (in_instr[6:0] == c_OPC_OPIMM) begin
            w_dec.is_arith = 1'b1;
            w_dec.is_imm   = 1'b1;
            w_dec.rs2      = 5'd0;
            w_dec.imm      = w_imm_i;
            if (w_funct3 == 3'b001 || w_funct3 == 3'b101) begin
                w_dec.imm = w_shamt;
                if (w_hi_zero)
                    w_dec.kind = base_kind(w_funct3);
                else if (w_hi_sra && w_funct3 == 3'b101)
                    w_dec.kind = c_K_SRA;
                else
                    w_dec.illegal = 1'b1;
            end else begin
                w_dec.kind = base_kind(w_funct3);
            end
        end else if (in_instr[6:0] == c_OPC_OP) begin
            w_dec.is_arith = 1'b1;
            case (w_funct7)
                7'b0000000: w_dec.kind = base_kind(w_funct3);
                7'b0100000: begin
                    if (w_funct3 == 3'b000)
                        w_dec.kind = c_K_SUB;
                    else if (w_funct3 == 3'b101)
                        w_dec.kind = c_K_SRA;
                    else
                        w_dec.illegal = 1'b1;
                end
`ifdef DECODE_ARITH_MEXT_EN
                7'b0000001: w_dec.kind = 5'd10 + {2'b00, w_funct3};
`else
                7'b0000001: w_dec.illegal = 1'b1;
`endif
                default:    w_dec.illegal = 1'b1;
            endcase
        end
    end

    assign in_ready  = ~rst & (r_state != ST_TWO);
    assign out_valid = ~rst & (r_state != ST_EMPTY);
    assign w_accept  = in_valid & in_ready & ~flush;
    assign w_out_hs  = out_valid & out_ready;

    always_ff @(posedge clk) begin
        if (rst)
            r_state <= ST_EMPTY;
        else
            r_state <= w_next_state;
    end

    always_comb begin
        w_next_state     = r_state;
        w_load_main_in   = 1'b0;
        w_load_main_skid = 1'b0;
        w_load_skid      = 1'b0;
        if (flush) begin
            w_next_state = ST_EMPTY;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_accept) begin
                        w_next_state   = ST_ONE;
                        w_load_main_in = 1'b1;
                    end
                end
                ST_ONE: begin
                    if (w_accept && w_out_hs) begin
                        w_load_main_in = 1'b1;
                    end else if (w_accept) begin
                        w_next_state = ST_TWO;
                        w_load_skid  = 1'b1;
                    end else if (w_out_hs) begin
                        w_next_state = ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    if (w_out_hs) begin
                        w_next_state     = ST_ONE;
                        w_load_main_skid = 1'b1;
                    end
                end
                default: w_next_state = ST_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_main          <= '0;
            r_skid          <= '0;
            r_illegal_count <= '0;
        end else begin
            if (w_load_main_in)
                r_main <= w_dec;
            else if (w_load_main_skid)
                r_main <= r_skid;
            if (w_load_skid)
                r_skid <= w_dec;
            if (w_accept && w_dec.illegal && !(&r_illegal_count))
                r_illegal_count <= r_illegal_count + 1'b1;
        end
    end

    assign out_kind      = r_main.kind;
    assign out_is_imm    = r_main.is_imm;
    assign out_is_arith  = r_main.is_arith;
    assign out_illegal   = r_main.illegal;
    assign out_rd        = r_main.rd;
    assign out_rs1       = r_main.rs1;
    assign out_rs2       = r_main.rs2;
    assign out_imm       = r_main.imm;
    assign illegal_count = r_illegal_count;

endmodule

`default_nettype wire

// File: tb/tb_decode_arith_stage.sv
// ============================================================================
// Module   : tb_decode_arith_stage
// Brief    : Directed scoreboard bench for decode_arith_stage (XLEN=32, CNT_W=2).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_decode_arith_stage;

    localparam int XLEN  = 32;
    localparam int CNT_W = 2;

    logic             clk;
    logic             rst;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_instr;
    logic             out_valid;
    logic             out_ready;
    logic [4:0]       out_kind;
    logic             out_is_imm;
    logic             out_is_arith;
    logic             out_illegal;
    logic [4:0]       out_rd;
    logic [4:0]       out_rs1;
    logic [4:0]       out_rs2;
    logic [XLEN-1:0]  out_imm;
    logic [CNT_W-1:0] illegal_count;

    decode_arith_stage #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_kind(out_kind), .out_is_imm(out_is_imm), .out_is_arith(out_is_arith),
        .out_illegal(out_illegal), .out_rd(out_rd), .out_rs1(out_rs1),
        .out_rs2(out_rs2), .out_imm(out_imm), .illegal_count(illegal_count)
    );

    typedef struct packed {
        logic [4:0]  kind;
        logic        is_imm;
        logic        is_arith;
        logic        illegal;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
    } exp_t;

    exp_t     q[$];
    exp_t     cur;
    int       n_checks;
    int       n_errors;
    int       exp_count;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t mk(input logic [4:0] k, input logic im, input logic ar,
                                input logic il, input logic [4:0] rd, input logic [4:0] rs1,
                                input logic [4:0] rs2, input logic [31:0] imm);
        exp_t e;
        e.kind = k; e.is_imm = im; e.is_arith = ar; e.illegal = il;
        e.rd = rd; e.rs1 = rs1; e.rs2 = rs2; e.imm = imm;
        return e;
    endfunction

    // One clock: sample at the falling edge, then let the rising edge happen
    task automatic step();
        exp_t e;
        logic acc, hs;
        @(negedge clk);
        if (!rst) begin
            chk("illegal_count", 64'(illegal_count), 64'(exp_count));
            chk("out_valid_occ", 64'(out_valid), 64'(q.size() > 0));
            chk("in_ready_occ", 64'(in_ready), 64'(q.size() < 2));
        end
        acc = in_valid && in_ready && !flush && !rst;
        hs  = out_valid && out_ready;
        if (hs) begin
            if (q.size() == 0) begin
                chk("spurious_output", 64'(1), 64'(0));
            end else begin
                e = q.pop_front();
                chk("kind", 64'(out_kind), 64'(e.kind));
                chk("is_imm", 64'(out_is_imm), 64'(e.is_imm));
                chk("is_arith", 64'(out_is_arith), 64'(e.is_arith));
                chk("illegal", 64'(out_illegal), 64'(e.illegal));
                chk("rd", 64'(out_rd), 64'(e.rd));
                chk("rs1", 64'(out_rs1), 64'(e.rs1));
                chk("rs2", 64'(out_rs2), 64'(e.rs2));
                chk("imm", 64'(out_imm), 64'(e.imm));
            end
        end
        if (rst || flush) q.delete();
        if (rst) exp_count = 0;
        if (acc) begin
            q.push_back(cur);
            if (cur.illegal && exp_count != (1 << CNT_W) - 1) exp_count++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [31:0] instr, input exp_t e);
        in_valid = 1'b1;
        in_instr = instr;
        cur      = e;
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 10 && q.size() > 0; i++) step();
        chk("drain_empty", 64'(q.size()), 64'(0));
    endtask

    exp_t e_addi, e_srai, e_mul, e_slli, e_sub, e_badop, e_lui, e_andi;
    exp_t e_w1, e_w2, e_w3;

    initial begin
        n_checks = 0; n_errors = 0; exp_count = 0;
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_instr = '0; out_ready = 1'b1;
        cur = '0;

        e_addi  = mk(5'd0,  1, 1, 0, 5'd1,  5'd0,  5'd0,  32'hFFFF_FFFF);
        e_srai  = mk(5'd7,  1, 1, 0, 5'd5,  5'd6,  5'd0,  32'd3);
`ifdef DECODE_ARITH_MEXT_EN
        e_mul   = mk(5'd10, 0, 1, 0, 5'd3,  5'd1,  5'd2,  32'd0);
`else
        e_mul   = mk(5'd31, 0, 1, 1, 5'd3,  5'd1,  5'd2,  32'd0);
`endif
        e_slli  = mk(5'd31, 1, 1, 1, 5'd1,  5'd1,  5'd0,  32'd1);
        e_sub   = mk(5'd1,  0, 1, 0, 5'd10, 5'd11, 5'd12, 32'd0);
        e_badop = mk(5'd31, 0, 1, 1, 5'd10, 5'd11, 5'd12, 32'd0);
        e_lui   = mk(5'd31, 0, 0, 0, 5'd1,  5'd8,  5'd3,  32'd0);
        e_andi  = mk(5'd9,  1, 1, 0, 5'd7,  5'd8,  5'd0,  32'h7FF);
        e_w1    = mk(5'd0,  1, 1, 0, 5'd2,  5'd0,  5'd0,  32'd5);
        e_w2    = mk(5'd0,  1, 1, 0, 5'd3,  5'd0,  5'd0,  32'd6);
        e_w3    = mk(5'd0,  1, 1, 0, 5'd4,  5'd0,  5'd0,  32'd7);

        // Reset
        repeat (2) step();
        chk("rst_in_ready", 64'(in_ready), 64'(0));
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        rst = 1'b0;
        chk("rst_kind", 64'(out_kind), 64'(0));
        chk("rst_imm", 64'(out_imm), 64'(0));
        chk("rst_rd", 64'(out_rd), 64'(0));
        chk("rst_count", 64'(illegal_count), 64'(0));
        step();

        // Back-to-back decode stream, counter saturates at 3
        offer(32'hFFF00093, e_addi);  step();
        offer(32'h40335293, e_srai);  step();
        offer(32'h022081B3, e_mul);   step();
        offer(32'h02109093, e_slli);  step();
        offer(32'h40C58533, e_sub);   step();
        offer(32'h40C59533, e_badop); step();
        offer(32'h123450B7, e_lui);   step();
        offer(32'h7FF47393, e_andi);  step();
        offer(32'h02109093, e_slli);  step();
        drain();
        step();
        chk("count_saturated", 64'(illegal_count), 64'(3));

        // Back-pressure: two held, third stalls
        out_ready = 1'b0;
        offer(32'h00500113, e_w1); step();
        offer(32'h00600193, e_w2); step();
        chk("bp_in_ready_low", 64'(in_ready), 64'(0));
        offer(32'h00700213, e_w3); step();
        out_ready = 1'b1;
        step();
        step();
        chk("bp_in_ready_back", 64'(in_ready), 64'(1));
        drain();

        // Flush with two entries held; concurrent illegal word dropped
        out_ready = 1'b0;
        offer(32'h00500113, e_w1); step();
        offer(32'h00600193, e_w2); step();
        flush = 1'b1;
        offer(32'h02109093, e_slli); step();
        flush = 1'b0;
        in_valid = 1'b0;
        chk("flush_out_valid", 64'(out_valid), 64'(0));
        step();
        step();

        // Reset mid-transfer
        offer(32'h00500113, e_w1); step();
        offer(32'h00600193, e_w2); step();
        rst = 1'b1;
        in_valid = 1'b0;
        step();
        chk("midrst_out_valid", 64'(out_valid), 64'(0));
        chk("midrst_in_ready", 64'(in_ready), 64'(0));
        rst = 1'b0;
        chk("midrst_count", 64'(illegal_count), 64'(0));
        chk("midrst_kind", 64'(out_kind), 64'(0));
        out_ready = 1'b1;
        step();
        offer(32'h7FF47393, e_andi); step();
        drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/decode_arith_stage.md
# decode_arith_stage

Registered, parametrised decode stage for RV32I/RV64I integer arithmetic (OP-IMM and OP opcodes). It accepts raw instruction words over a valid/ready handshake and emits a unified arithmetic kind, register indices, a sign-extended immediate and legality flags one cycle later. A two-entry skid buffer sits between fetch and the execute issue logic, and a saturating illegal-instruction counter feeds the debug CSR block.

## Interface
- `XLEN`, default 32: datapath width; legal values are 32 and 64. It sets the immediate width and the shamt width (5 or 6 bits).
- `CNT_W`, default 16: width of `illegal_count`.
- `clk`, input, 1: clock; all state changes on its rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `flush`, input, 1: synchronous; drops both buffered entries.
- `in_valid`, input, 1: instruction word present.
- `in_ready`, output, 1: stage can accept a word this cycle.
- `in_instr`, input, 32: raw instruction word.
- `out_valid`, output, 1: decoded bundle present.
- `out_ready`, input, 1: consumer accepts the bundle.
- `out_kind`, output, 5: arithmetic kind code.
- `out_is_imm`, output, 1: operand B is the immediate (OP-IMM).
- `out_is_arith`, output, 1: opcode is 0010011 or 0110011.
- `out_illegal`, output, 1: arithmetic opcode with an invalid funct3/funct7 combination.
- `out_rd`, `out_rs1`, `out_rs2`, output, 5 each: register indices (`rs2` is forced to 0 when `is_imm` = 1).
- `out_imm`, output, XLEN: I-immediate sign-extended to XLEN; shamt zero-extended for shifts; 0 for OP.
- `illegal_count`, output, CNT_W: saturating count of accepted illegal words.

## Operation
- **Kind codes:** ADD 0, SUB 1, SLL 2, SLT 3, SLTU 4, XOR 5, SRL 6, SRA 7, OR 8, AND 9, MUL 10, MULH 11, MULHSU 12, MULHU 13, DIV 14, DIVU 15, REM 16, REMU 17, INVALID 31.
- **OP-IMM decoding:**
  - funct3 000, 010, 011, 100, 110, 111 map to ADD, SLT, SLTU, XOR, OR, AND.
  - funct3 001 and 101 are shifts. The high-bit check depends on XLEN:
    - XLEN=32: checks `instr[31:25]`.
    - XLEN=64: checks `instr[31:26]`, and `instr[25]` is `shamt[5]`.
  - High bits all zero give SLL or SRL. High bits 0100000 (or 010000 for XLEN=64) with funct3 101 give SRA.
  - Any other high-bit pattern gives INVALID with illegal=1.
  - XLEN=32 with `instr[25]`=1 on a shift is illegal.
- **OP decoding:**
  - funct7 0000000 selects the base op by funct3.
  - funct7 0100000 is legal only with funct3 000 (SUB) and 101 (SRA).
  - funct7 0000001 selects the M ops; see Configuration.
  - Everything else is INVALID with illegal=1.
- **Non-arithmetic opcodes:** is_arith=0, illegal=0, kind=INVALID; the word is passed through so downstream decoders may claim it.
- **Skid buffer states:**
  - EMPTY: `in_ready`=1, `out_valid`=0.
  - ONE: the main register is valid.
  - TWO: main and skid registers are both valid, `in_ready`=0.
- **Transitions:**
  - EMPTY→ONE on input accept.
  - ONE→TWO on accept without output handshake.
  - ONE→EMPTY on output handshake without accept.
  - ONE→ONE on accept and output handshake together; the main register is replaced.
  - TWO→ONE on output handshake; skid moves to main.
- **Flush:** moves to EMPTY from any state. A word offered in the same cycle is not accepted and not counted.
- **Illegal counter:** `illegal_count` increments when an accepted word decodes illegal, and saturates at all ones.

## Timing
- Latency is 1 cycle from accept (`in_valid` & `in_ready`) to `out_valid`.
- Throughput is 1 word per cycle while `out_ready`=1.
- `in_ready` is a function of state only. It is never combinationally dependent on `out_ready`.
- Output bundle fields hold stable while `out_valid`=1 and `out_ready`=0.
- During `rst` and in the cycle it is sampled:
  - state goes to EMPTY and `out_valid`=0;
  - `in_ready`=0 while `rst`=1;
  - all bundle fields reset to 0 and `illegal_count`=0.
- Reset asserted mid-transfer discards both entries.
- Reset has priority over flush.

## Configuration
- `DECODE_ARITH_MEXT_EN` defined: funct7 0000001 with opcode OP decodes, by funct3 000–111, to MUL…REMU (codes 10–17).
- `DECODE_ARITH_MEXT_EN` undefined: funct7 0000001 gives INVALID with illegal=1, and codes 10–17 are never produced.

## Test plan
- Reset, then 0xFFF00093 (ADDI x1,x0,-1): one cycle later kind=0, is_imm=1, rd=1, rs1=0, imm=all ones (XLEN bits).
- 0x40335293 (SRAI x5,x6,3): kind=7, rd=5, rs1=6, imm=3, illegal=0.
- 0x022081B3 (MUL x3,x1,x2): with the macro, kind=10, rs1=1, rs2=2. Without it, kind=31, illegal=1, and `illegal_count` goes 0→1.
- 0x02109093 (SLLI, bit25=1): with XLEN=32, illegal=1. With XLEN=64, kind=2 and imm=33.
- Back-pressure sequence:
  - Hold `out_ready`=0 and stream 3 words. The first two are accepted and `in_ready`=0 from the cycle after the second.
  - Raise `out_ready`: outputs appear in order and `in_ready` returns to 1.
  - Assert `flush` with 2 entries held: `out_valid`=0 next cycle, and a concurrently offered word is dropped.
